// File: rtl/mem_vga_port.sv
// mem_vga_port: MEM-stage VGA responder with framebuffer write FIFO, control registers and
// optional framebuffer-clear engine (enabled by defining VGA_PORT_CLEAR_EN).
package mem_vga_pkg;
  typedef struct packed {
    logic memRead;
    logic memWrite;
  } mem_ctrl_t;
endpackage

module mem_vga_port
  import mem_vga_pkg::*;
#(
  parameter int FB_AW      = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  mem_ctrl_t        i_ctrlVGA,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wrData,
  output logic [31:0]      o_rdData,
  output logic             o_rdValid,
  output logic             o_stall,
  input  logic             i_fbReady,
  output logic             o_fbWe,
  output logic [FB_AW-1:0] o_fbAddr,
  output logic [31:0]      o_fbData,
  input  logic             i_vsync,
  output logic             o_dispEn,
  output logic [FB_AW-1:0] o_scroll
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic             wr, rd, is_reg, fb_req, full, busy, push, pop, in_clear;
  logic [1:0]       off;
  logic [PW:0]      count;
  logic [PW-1:0]    wp, rp;
  logic [FB_AW-1:0] fifo_a [FIFO_DEPTH];
  logic [31:0]      fifo_d [FIFO_DEPTH];
  logic [15:0]      frame_cnt;
  logic [31:0]      rsel, clear_val;
  logic [FB_AW-1:0] clr_cnt;
  logic             unused_bits;
  assign wr      = i_ctrlVGA.memWrite;
  assign rd      = i_ctrlVGA.memRead & ~i_ctrlVGA.memWrite;
  assign is_reg  = i_addr[27];
  assign off     = i_addr[3:2];
  assign fb_req  = wr & ~is_reg;
  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign o_stall = fb_req & (full | busy);
  assign push    = fb_req & ~o_stall;
  assign pop     = ~in_clear & (count != '0) & i_fbReady;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge i_clk)
    if (push) begin
      fifo_a[wp] <= i_addr[FB_AW+1:2];
      fifo_d[wp] <= i_wrData;
    end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_dispEn  <= 1'b0;
      o_scroll  <= '0;
      frame_cnt <= '0;
      o_rdValid <= 1'b0;
      o_rdData  <= '0;
    end else begin
      if (wr && is_reg && off == 2'd0) o_dispEn <= i_wrData[0];
      if (wr && is_reg && off == 2'd1) o_scroll <= i_wrData[FB_AW-1:0];
      if (i_vsync) frame_cnt <= frame_cnt + 1'b1;
      o_rdValid <= rd;
      o_rdData  <= rd ? rsel : '0;
    end
  always_comb
    rsel = !is_reg      ? '0 :
           off == 2'd0  ? {30'b0, busy, o_dispEn} :
           off == 2'd1  ? 32'(o_scroll) :
           off == 2'd2  ? clear_val :
                          {frame_cnt, 7'b0, busy, 8'(count)};
`ifdef VGA_PORT_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
  state_t state, state_nx;
  logic   clr_start;
  assign clr_start = wr & is_reg & (off == 2'd0) & i_wrData[1] & ~busy;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (clr_start ? DRAIN : IDLE) :
               state == DRAIN ? (count == '0 ? CLEAR : DRAIN) :
               (i_fbReady && &clr_cnt) ? IDLE : CLEAR;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      clear_val <= '0;
      clr_cnt   <= '0;
    end else begin
      if (wr && is_reg && off == 2'd2) clear_val <= i_wrData;
      clr_cnt <= state == DRAIN ? '0 : (state == CLEAR && i_fbReady) ? clr_cnt + 1'b1 : clr_cnt;
    end
  assign busy     = state != IDLE;
  assign in_clear = state == CLEAR;
  assign unused_bits = ^{i_addr[31:28], i_addr[26:FB_AW+2], i_addr[1:0]};
`else
  assign busy      = 1'b0;
  assign in_clear  = 1'b0;
  assign clear_val = '0;
  assign clr_cnt   = '0;
  assign unused_bits = ^{i_addr[31:28], i_addr[26:FB_AW+2], i_addr[1:0], i_wrData};
`endif
  always_comb begin
    o_fbWe   = in_clear ? i_fbReady : pop;
    o_fbAddr = in_clear ? clr_cnt : pop ? fifo_a[rp] : '0;
    o_fbData = in_clear ? clear_val : pop ? fifo_d[rp] : '0;
  end
endmodule

// File: tb/tb_mem_vga_port.sv
// tb_mem_vga_port: directed self-checking bench for mem_vga_port (FB_AW=10, FIFO_DEPTH=4);
// exercises the clear engine when VGA_PORT_CLEAR_EN is defined.
module tb_mem_vga_port;
  import mem_vga_pkg::*;
  localparam int AW = 10;
  localparam logic [31:0] FB = 32'h1000_0000;
  localparam logic [31:0] RG = 32'h1800_0000;
`ifdef VGA_PORT_CLEAR_EN
  localparam logic [31:0] CV = 32'h55;
`else
  localparam logic [31:0] CV = 32'h0;
`endif
  logic          i_clk = 1'b0;
  logic          i_reset_n;
  mem_ctrl_t     ctrl;
  logic [31:0]   i_addr, i_wrData, o_rdData, o_fbData;
  logic          o_rdValid, o_stall, i_fbReady, o_fbWe, i_vsync, o_dispEn;
  logic [AW-1:0] o_fbAddr, o_scroll;
  int checks = 0;
  int errors = 0;

  mem_vga_port #(.FB_AW(AW), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ctrlVGA(ctrl), .i_addr(i_addr),
    .i_wrData(i_wrData), .o_rdData(o_rdData), .o_rdValid(o_rdValid), .o_stall(o_stall),
    .i_fbReady(i_fbReady), .o_fbWe(o_fbWe), .o_fbAddr(o_fbAddr), .o_fbData(o_fbData),
    .i_vsync(i_vsync), .o_dispEn(o_dispEn), .o_scroll(o_scroll)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    ctrl.memRead = r; ctrl.memWrite = w; i_addr = a; i_wrData = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    idle();
    check({tag, "_valid"}, 32'(o_rdValid), 32'h1);
    check(tag, o_rdData, exp);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rdValid"}, 32'(o_rdValid), 32'h0);
    check({tag, "_rdData"}, o_rdData, 32'h0);
    check({tag, "_stall"}, 32'(o_stall), 32'h0);
    check({tag, "_fbWe"}, 32'(o_fbWe), 32'h0);
    check({tag, "_fbAddr"}, 32'(o_fbAddr), 32'h0);
    check({tag, "_fbData"}, o_fbData, 32'h0);
    check({tag, "_dispEn"}, 32'(o_dispEn), 32'h0);
    check({tag, "_scroll"}, 32'(o_scroll), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0; ctrl = '0; i_addr = '0; i_wrData = '0; i_fbReady = 1'b1; i_vsync = 1'b0;
    @(negedge i_clk); @(negedge i_clk); #1;
    chk_zero("reset");
    @(negedge i_clk); i_reset_n = 1'b1;

    drive(1'b0, 1'b1, FB | 32'h10, 32'hDEADBEEF);
    check("st1_stall", 32'(o_stall), 32'h0);
    idle();
    check("st1_we", 32'(o_fbWe), 32'h1);
    check("st1_addr", 32'(o_fbAddr), 32'h4);
    check("st1_data", o_fbData, 32'hDEADBEEF);
    idle();
    check("st1_we_off", 32'(o_fbWe), 32'h0);

    i_fbReady = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, FB | 32'(k * 4), 32'h100 + 32'(k));
      check("fill_stall", 32'(o_stall), 32'h0);
    end
    rd_chk("status_full", RG | 32'hC, 32'h0000_0004);
    drive(1'b0, 1'b1, FB | 32'h14, 32'h105);
    check("full_stall", 32'(o_stall), 32'h1);
    drive(1'b0, 1'b1, FB | 32'h14, 32'h105);
    i_fbReady = 1'b1; #1;
    check("full_pop_stall", 32'(o_stall), 32'h1);
    check("pop1_we", 32'(o_fbWe), 32'h1);
    check("pop1_addr", 32'(o_fbAddr), 32'h1);
    check("pop1_data", o_fbData, 32'h101);
    drive(1'b0, 1'b1, FB | 32'h14, 32'h105);
    check("accept5_stall", 32'(o_stall), 32'h0);
    check("pop2_addr", 32'(o_fbAddr), 32'h2);
    check("pop2_data", o_fbData, 32'h102);
    idle();
    check("pop3_addr", 32'(o_fbAddr), 32'h3);
    idle();
    check("pop4_addr", 32'(o_fbAddr), 32'h4);
    idle();
    check("pop5_we", 32'(o_fbWe), 32'h1);
    check("pop5_addr", 32'(o_fbAddr), 32'h5);
    check("pop5_data", o_fbData, 32'h105);
    idle();
    check("empty_we", 32'(o_fbWe), 32'h0);

    drive(1'b0, 1'b1, RG | 32'h4, 32'h123);
    check("reg_stall", 32'(o_stall), 32'h0);
    drive(1'b0, 1'b1, RG, 32'h1);
    idle();
    check("scroll_out", 32'(o_scroll), 32'h123);
    check("dispen_out", 32'(o_dispEn), 32'h1);
    drive(1'b1, 1'b0, RG | 32'h4, 32'h0);
    drive(1'b1, 1'b0, RG, 32'h0);
    check("rd_scroll_valid", 32'(o_rdValid), 32'h1);
    check("rd_scroll", o_rdData, 32'h123);
    idle();
    check("rd_ctrl_valid", 32'(o_rdValid), 32'h1);
    check("rd_ctrl", o_rdData, 32'h1);
    idle();
    check("rd_valid_pulse", 32'(o_rdValid), 32'h0);

    rd_chk("fb_load", FB | 32'h10, 32'h0);
    drive(1'b1, 1'b1, RG | 32'h4, 32'h55);
    idle();
    check("rw_no_valid", 32'(o_rdValid), 32'h0);
    check("rw_scroll", 32'(o_scroll), 32'h55);

    drive(1'b0, 1'b1, RG | 32'hC, 32'hFFFF_FFFF);
    idle();
    for (int i = 0; i < 3; i++) begin
      i_vsync = 1'b1;
      @(negedge i_clk);
      i_vsync = 1'b0;
      @(negedge i_clk);
    end
    rd_chk("status_frames", RG | 32'hC, 32'h0003_0000);
    drive(1'b0, 1'b1, RG | 32'h8, 32'h55);
    rd_chk("clearval", RG | 32'h8, CV);

`ifdef VGA_PORT_CLEAR_EN
    i_fbReady = 1'b0;
    drive(1'b0, 1'b1, FB | 32'h20, 32'h11);
    drive(1'b0, 1'b1, FB | 32'h24, 32'h22);
    drive(1'b0, 1'b1, RG, 32'h3);
    check("clr_cmd_stall", 32'(o_stall), 32'h0);
    drive(1'b0, 1'b1, FB | 32'h28, 32'h33);
    check("drain_stall", 32'(o_stall), 32'h1);
    check("drain_hold_we", 32'(o_fbWe), 32'h0);
    drive(1'b1, 1'b0, RG, 32'h0);
    i_fbReady = 1'b1; #1;
    check("drain1_addr", 32'(o_fbAddr), 32'h8);
    check("drain1_data", o_fbData, 32'h11);
    idle();
    check("busy_ctrl", o_rdData, 32'h3);
    check("drain2_addr", 32'(o_fbAddr), 32'h9);
    check("drain2_data", o_fbData, 32'h22);
    idle();
    check("drain_done_we", 32'(o_fbWe), 32'h0);
    for (int i = 0; i < (1 << AW); i++) begin
      if (i == 3) begin
        drive(1'b0, 1'b1, FB | 32'h2C, 32'h44);
        check("clear_stall", 32'(o_stall), 32'h1);
      end else idle();
      check("clear_we", 32'(o_fbWe), 32'h1);
      check("clear_addr", 32'(o_fbAddr), 32'(i));
      check("clear_data", o_fbData, 32'h55);
    end
    idle();
    check("clear_end_we", 32'(o_fbWe), 32'h0);
    rd_chk("status_idle", RG | 32'hC, 32'h0003_0000);
    drive(1'b0, 1'b1, RG, 32'h3);
    idle(); idle(); idle();
    check("reclear_we", 32'(o_fbWe), 32'h1);
`else
    drive(1'b0, 1'b1, RG, 32'h3);
    rd_chk("ctrl_noclear", RG, 32'h1);
    rd_chk("status_nobusy", RG | 32'hC, 32'h0003_0000);
    drive(1'b0, 1'b1, FB | 32'h40, 32'hA5);
    check("noclear_stall", 32'(o_stall), 32'h0);
    idle();
    check("noclear_we", 32'(o_fbWe), 32'h1);
    check("noclear_addr", 32'(o_fbAddr), 32'h10);
    check("noclear_data", o_fbData, 32'hA5);
    i_fbReady = 1'b0;
    drive(1'b0, 1'b1, FB | 32'h44, 32'hB6);
    idle();
`endif

    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    i_fbReady = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge i_clk); i_reset_n = 1'b1;
    #1;
    check("post_reset_we", 32'(o_fbWe), 32'h0);
    rd_chk("post_status", RG | 32'hC, 32'h0);
    rd_chk("post_ctrl", RG, 32'h0);
    rd_chk("post_scroll", RG | 32'h4, 32'h0);
    rd_chk("post_clearval", RG | 32'h8, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
